// File: rtl/dual_dispatch_scheduler.sv
// dual_dispatch_scheduler
//   Decides each cycle how many of the two decoded instructions may enter the
//   reservation stations. Slot 1 is older and slot 2 is younger. Dispatch is
//   strictly in order. The block tracks free RS entries for each unit class
//   (ALU, MUL, FP, MEM) and the free ROB entries. It also hands out ROB tags
//   from a wrapping tail pointer.
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   valid1/valid2               slot holds a decoded instruction
//   alu/mul/fp/mem/br{1,2}      class flags from decode (br counts as ALU)
//   {alu,mul,fp,mem}_rel        RS entries freed this cycle (0..2)
//   rob_commit                  ROB entries retired this cycle (0..2)
//   flush                       squash: no dispatch, all credits restored
//   disp1/disp2                 combinational grants
//   tag1/tag2                   ROB tags for slot 1 / slot 2
//   stall                       a valid instruction was held this cycle
//   err                         sticky protocol error (multi-class or overflow)
module dual_dispatch_scheduler #(
    parameter int ALU_RS    = 4,
    parameter int MUL_RS    = 2,
    parameter int FP_RS     = 2,
    parameter int MEM_RS    = 4,
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid1,
    input  logic             valid2,
    input  logic             alu1,
    input  logic             mul1,
    input  logic             fp1,
    input  logic             mem1,
    input  logic             alu2,
    input  logic             mul2,
    input  logic             fp2,
    input  logic             mem2,
    input  logic             br1,
    input  logic             br2,
    input  logic [1:0]       alu_rel,
    input  logic [1:0]       mul_rel,
    input  logic [1:0]       fp_rel,
    input  logic [1:0]       mem_rel,
    input  logic [1:0]       rob_commit,
    input  logic             flush,
    output logic             disp1,
    output logic             disp2,
    output logic [TAG_W-1:0] tag1,
    output logic [TAG_W-1:0] tag2,
    output logic             stall,
    output logic             err
);

    // Two spare bits let a counter hold ROB_DEPTH. The sum width leaves
    // headroom so an overflowing value can be seen before it is saturated.
    localparam int CW  = TAG_W + 2;
    localparam int SW  = CW + 2;
    localparam int NCL = 4;

    typedef enum logic [2:0] {CL_NONE, CL_ALU, CL_MUL, CL_FP, CL_MEM} cls_e;

    // Counter index order is ALU, MUL, FP, MEM (bit 0 .. bit 3).
    localparam logic [NCL-1:0][CW-1:0] CAP =
        {CW'(MEM_RS), CW'(FP_RS), CW'(MUL_RS), CW'(ALU_RS)};

    function automatic cls_e slot_class(input logic a, m, f, l, b);
        if (l)          return CL_MEM;
        else if (f)     return CL_FP;
        else if (m)     return CL_MUL;
        else if (a | b) return CL_ALU;
        else            return CL_NONE;
    endfunction

    function automatic logic multi_flag(input logic a, m, f, l, b);
        logic [2:0] n;
        n = {2'b00, a | b} + {2'b00, m} + {2'b00, f} + {2'b00, l};
        return n > 3'd1;
    endfunction

    function automatic logic [NCL-1:0] onehot(input cls_e c);
        case (c)
            CL_ALU:  return 4'b0001;
            CL_MUL:  return 4'b0010;
            CL_FP:   return 4'b0100;
            CL_MEM:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    logic [NCL-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]          rob_free_q, rob_free_d;
    logic [TAG_W-1:0]       rob_tail_q, rob_tail_d;
    logic                   err_q, err_d;

    cls_e                   cls1, cls2;
    logic [NCL-1:0]         oh1, oh2, nz, ge2;
    logic                   same_cls, res1_ok, res2_ok;
    logic                   disp1_c, disp2_c;
    logic [NCL-1:0][1:0]    rel;

    assign rel = {mem_rel, fp_rel, mul_rel, alu_rel};

    always_comb begin
        cls1 = slot_class(alu1, mul1, fp1, mem1, br1);
        cls2 = slot_class(alu2, mul2, fp2, mem2, br2);
        oh1  = onehot(cls1);
        oh2  = onehot(cls2);
        for (int k = 0; k < NCL; k++) begin
            nz[k]  = cnt_q[k] != '0;
            ge2[k] = cnt_q[k] >= CW'(2);
        end
        // Grants look only at the registered (pre-release) counters. When both
        // slots use the same class, slot 2 needs the second free entry.
        same_cls = (cls1 == cls2) && (cls1 != CL_NONE);
        res1_ok  = (cls1 == CL_NONE) || |(oh1 & nz);
        res2_ok  = (cls2 == CL_NONE) || (same_cls ? |(oh2 & ge2) : |(oh2 & nz));
        disp1_c  = ~rst & ~flush & valid1 & res1_ok & (rob_free_q >= CW'(1));
        disp2_c  = disp1_c & valid2 & res2_ok & (rob_free_q >= CW'(2));
    end

    assign disp1 = disp1_c;
    assign disp2 = disp2_c;
    assign tag1  = rob_tail_q;
    assign tag2  = rob_tail_q + TAG_W'(1);   // power-of-two depth wraps naturally
    assign stall = ~rst & ((valid1 & ~disp1_c) | (valid2 & ~disp2_c));
    assign err   = err_q;

    always_comb begin
        logic [SW-1:0] sum;
        logic [1:0]    used;
        sum        = '0;
        used       = '0;
        cnt_d      = cnt_q;
        rob_free_d = rob_free_q;
        rob_tail_d = rob_tail_q;
        err_d      = err_q;

        if ((valid1 & multi_flag(alu1, mul1, fp1, mem1, br1)) |
            (valid2 & multi_flag(alu2, mul2, fp2, mem2, br2)))
            err_d = 1'b1;

        if (flush) begin
            // Squash restores every credit. The tail is kept so that tags stay
            // monotonic across the flush.
            cnt_d      = CAP;
            rob_free_d = CW'(ROB_DEPTH);
        end else begin
            for (int k = 0; k < NCL; k++) begin
                used = {1'b0, disp1_c & oh1[k]} + {1'b0, disp2_c & oh2[k]};
                sum  = SW'(cnt_q[k]) - SW'(used) + SW'(rel[k]);
                if (sum > SW'(CAP[k])) begin
                    cnt_d[k] = CAP[k];
                    err_d    = 1'b1;
                end else begin
                    cnt_d[k] = sum[CW-1:0];
                end
            end
            used = {1'b0, disp1_c} + {1'b0, disp2_c};
            sum  = SW'(rob_free_q) - SW'(used) + SW'(rob_commit);
            if (sum > SW'(ROB_DEPTH)) begin
                rob_free_d = CW'(ROB_DEPTH);
                err_d      = 1'b1;
            end else begin
                rob_free_d = sum[CW-1:0];
            end
            rob_tail_d = rob_tail_q + TAG_W'(used);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= CAP;
            rob_free_q <= CW'(ROB_DEPTH);
            rob_tail_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rob_free_q <= rob_free_d;
            rob_tail_q <= rob_tail_d;
            err_q      <= err_d;
        end
    end

endmodule
